// File: rtl/g_aetcam_wr_ctrl.sv
// Write-side controller for a dual-port ternary CAM array.
// Accepts WRITE / INVALIDATE / CLEAR_ALL commands over valid/ready and drives the
// array's port-0 write bus plus the per-entry valid vector used by the search path.
// Optional macro G_AETCAM_SHADOW_EN adds a readable shadow copy of all entries.
module g_aetcam_wr_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [AW-1:0]    cmd_addr_i,
    input  logic [WIDTH-1:0] cmd_value_i,
    input  logic [WIDTH-1:0] cmd_mask_i,
    output logic [DEPTH-1:0] wen_o,
    output logic [WIDTH-1:0] w_st_o,
    output logic [WIDTH-1:0] w_m_o,
    output logic [DEPTH-1:0] valid_vec_o,
    output logic             busy_o,
    output logic             done_o,
`ifdef G_AETCAM_SHADOW_EN
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_st_o,
    output logic [WIDTH-1:0] rd_m_o,
    output logic             rd_valid_o,
`endif
    output logic             err_o
);

    typedef enum logic [1:0] {StIdle, StWr, StClr} state_e;

    localparam logic [1:0]    OpWrite = 2'd0;
    localparam logic [1:0]    OpInval = 2'd1;
    localparam logic [1:0]    OpClear = 2'd2;
    localparam logic [1:0]    OpRsvd  = 2'd3;
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic               set_q, set_d;   // 1: WRITE sets valid, 0: INVALIDATE clears it
    logic               err_q, err_d;
    logic [WIDTH-1:0]   w_st_q, w_st_d;
    logic [WIDTH-1:0]   w_m_q, w_m_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               cmd_bad;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign cmd_bad = (cmd_op_i == OpRsvd) || (32'(cmd_addr_i) >= DEPTH);

    assign cmd_ready_o = (state_q == StIdle) && rst_n;
    assign busy_o      = (state_q != StIdle);
    assign w_st_o      = w_st_q;
    assign w_m_o       = w_m_q;
    assign valid_vec_o = valid_q;

    // Next-state and write-bus outputs; bus data only changes at command acceptance.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        set_d   = set_q;
        err_d   = err_q;
        w_st_d  = w_st_q;
        w_m_d   = w_m_q;
        valid_d = valid_q;
        wen_o   = '0;
        done_o  = 1'b0;
        err_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    if (cmd_op_i == OpClear) begin
                        state_d = StClr;
                        cnt_d   = '0;
                        w_st_d  = '0;
                        w_m_d   = '0;
                    end else begin
                        state_d = StWr;
                        err_d   = cmd_bad;
                        set_d   = (cmd_op_i == OpWrite);
                        if (!cmd_bad) begin
                            // Masked bits are stored as 0 so entries compare canonically.
                            w_st_d = (cmd_op_i == OpWrite) ? (cmd_value_i & ~cmd_mask_i) : '0;
                            w_m_d  = (cmd_op_i == OpWrite) ? cmd_mask_i : '0;
                        end
                    end
                end
            end
            StWr: begin
                state_d = StIdle;
                err_d   = 1'b0;
                done_o  = 1'b1;
                err_o   = err_q;
                if (!err_q) begin
                    wen_o[addr_q]   = 1'b1;
                    valid_d[addr_q] = set_q;
                end
            end
            StClr: begin
                wen_o[cnt_q]   = 1'b1;
                valid_d[cnt_q] = 1'b0;
                if (cnt_q == LastIdx) begin
                    done_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            set_q   <= 1'b0;
            err_q   <= 1'b0;
            w_st_q  <= '0;
            w_m_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            err_q   <= err_d;
            w_st_q  <= w_st_d;
            w_m_q   <= w_m_d;
            valid_q <= valid_d;
        end
    end

`ifdef G_AETCAM_SHADOW_EN
    logic [WIDTH-1:0] sh_st_q [DEPTH];
    logic [WIDTH-1:0] sh_m_q  [DEPTH];
    logic [WIDTH-1:0] rd_st_q, rd_m_q;
    logic             rd_valid_q;
    logic             rd_in_range;

    assign rd_in_range = (32'(rd_addr_i) < DEPTH);
    assign rd_st_o     = rd_st_q;
    assign rd_m_o      = rd_m_q;
    assign rd_valid_o  = rd_valid_q;

    // Shadow copy mirrors every array write; reads see pre-write data on a collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                sh_st_q[i] <= '0;
                sh_m_q[i]  <= '0;
            end
            rd_st_q    <= '0;
            rd_m_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wen_o[i]) begin
                    sh_st_q[i] <= w_st_q;
                    sh_m_q[i]  <= w_m_q;
                end
            end
            rd_st_q    <= rd_in_range ? sh_st_q[rd_addr_i] : '0;
            rd_m_q     <= rd_in_range ? sh_m_q[rd_addr_i] : '0;
            rd_valid_q <= rd_in_range ? valid_q[rd_addr_i] : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_g_aetcam_wr_ctrl.sv
// Bench for g_aetcam_wr_ctrl: a DEPTH=64 and a DEPTH=48 instance share stimulus;
// expected write-bus results are queued at issue and popped on each done pulse.
module tb_g_aetcam_wr_ctrl;

    typedef struct {
        logic [63:0] wen;
        logic [31:0] st;
        logic [31:0] m;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        sel48;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_value;
    logic [31:0] cmd_mask;

    logic        rdy_a, busy_a, done_a, err_a;
    logic [63:0] wen_a, vv_a;
    logic [31:0] st_a, m_a;
    logic        rdy_b, busy_b, done_b, err_b;
    logic [47:0] wen_b, vv_b;
    logic [31:0] st_b, m_b;

    logic        rdy, busy, done, err;
    logic [63:0] wen, vv;
    logic [31:0] w_st, w_m;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [63:0] mv[2];
    logic [31:0] lst[2];
    logic [31:0] lm[2];

`ifdef G_AETCAM_SHADOW_EN
    logic [5:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_st_a, rd_m_a, rd_st_b, rd_m_b;
    logic        rd_valid_a, rd_valid_b;
`endif

    g_aetcam_wr_ctrl #(.WIDTH(32), .DEPTH(64)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid & ~sel48),
        .cmd_ready_o (rdy_a),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_value_i (cmd_value),
        .cmd_mask_i  (cmd_mask),
        .wen_o       (wen_a),
        .w_st_o      (st_a),
        .w_m_o       (m_a),
        .valid_vec_o (vv_a),
        .busy_o      (busy_a),
        .done_o      (done_a),
`ifdef G_AETCAM_SHADOW_EN
        .rd_addr_i   (rd_addr_a),
        .rd_st_o     (rd_st_a),
        .rd_m_o      (rd_m_a),
        .rd_valid_o  (rd_valid_a),
`endif
        .err_o       (err_a)
    );

    g_aetcam_wr_ctrl #(.WIDTH(32), .DEPTH(48)) dut48 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid & sel48),
        .cmd_ready_o (rdy_b),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_value_i (cmd_value),
        .cmd_mask_i  (cmd_mask),
        .wen_o       (wen_b),
        .w_st_o      (st_b),
        .w_m_o       (m_b),
        .valid_vec_o (vv_b),
        .busy_o      (busy_b),
        .done_o      (done_b),
`ifdef G_AETCAM_SHADOW_EN
        .rd_addr_i   (rd_addr_b),
        .rd_st_o     (rd_st_b),
        .rd_m_o      (rd_m_b),
        .rd_valid_o  (rd_valid_b),
`endif
        .err_o       (err_b)
    );

    assign rdy  = sel48 ? rdy_b : rdy_a;
    assign busy = sel48 ? busy_b : busy_a;
    assign done = sel48 ? done_b : done_a;
    assign err  = sel48 ? err_b : err_a;
    assign wen  = sel48 ? {16'h0, wen_b} : wen_a;
    assign vv   = sel48 ? {16'h0, vv_b} : vv_a;
    assign w_st = sel48 ? st_b : st_a;
    assign w_m  = sel48 ? m_b : m_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the write bus.
    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wen"}, wen, e.wen);
            chk({tag, "_st"}, 64'(w_st), 64'(e.st));
            chk({tag, "_m"}, 64'(w_m), 64'(e.m));
            chk({tag, "_err"}, 64'(err), 64'(e.err));
        end
    endtask

    // WRITE / INVALIDATE / error command: accept, one WR cycle, back to idle.
    task automatic do_cmd(input bit s48, input logic [1:0] op, input logic [5:0] a,
                          input logic [31:0] v, input logic [31:0] mk);
        exp_t e;
        int   s = s48 ? 1 : 0;
        int   d = s48 ? 48 : 64;
        bit   bad_cmd;
        @(negedge clk);
        sel48 = s48; cmd_op = op; cmd_addr = a; cmd_value = v; cmd_mask = mk;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 64'(rdy), 64'd1);
        bad_cmd = (int'(a) >= d) || (op == 2'd3);
        if (!bad_cmd) begin
            lst[s] = (op == 2'd0) ? (v & ~mk) : 32'h0;
            lm[s]  = (op == 2'd0) ? mk : 32'h0;
            mv[s][a] = (op == 2'd0);
        end
        e.wen = bad_cmd ? 64'h0 : (64'h1 << a);
        e.st  = lst[s];
        e.m   = lm[s];
        e.err = bad_cmd;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_value = 32'hDEAD_BEEF; cmd_mask = 32'h0; cmd_addr = 6'd0;
        chk("wr_busy", 64'(busy), 64'd1);
        chk("wr_done", 64'(done), 64'd1);
        if (done) pop_cmp("wr");
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_wen", wen, 64'h0);
        chk("valid_vec", vv, mv[s]);
    endtask

    // CLEAR_ALL on the DEPTH=64 instance; abort_at >= 0 asserts reset at that cycle.
    task automatic do_clear(input int abort_at);
        exp_t e;
        @(negedge clk);
        sel48 = 1'b0; cmd_op = 2'd2; cmd_addr = 6'd17; cmd_valid = 1'b1;
        chk("clr_ready_idle", 64'(rdy), 64'd1);
        lst[0] = 32'h0; lm[0] = 32'h0;
        e.wen = 64'h1 << 63; e.st = 32'h0; e.m = 32'h0; e.err = 1'b0;
        sb.push_back(e);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (i == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_wen", wen, 64'h0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_vv", vv, 64'h0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_ready", 64'(rdy), 64'd0);
                sb.delete();
                mv[0] = 64'h0; mv[1] = 64'h0;
                lst[0] = 32'h0; lm[0] = 32'h0; lst[1] = 32'h0; lm[1] = 32'h0;
                return;
            end
            chk("clr_wen", wen, 64'h1 << i);
            chk("clr_ready", 64'(rdy), 64'd0);
            chk("clr_busy", 64'(busy), 64'd1);
            chk("clr_st", 64'(w_st), 64'h0);
            chk("clr_done", 64'(done), (i == 63) ? 64'd1 : 64'd0);
            if (done) pop_cmp("clr");
        end
        mv[0] = 64'h0;
        @(negedge clk);
        chk("clr_vv", vv, 64'h0);
        chk("clr_ready_after", 64'(rdy), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; sel48 = 1'b0; cmd_op = 2'd0;
        cmd_addr = 6'd0; cmd_value = 32'h0; cmd_mask = 32'h0;
        mv[0] = 64'h0; mv[1] = 64'h0;
        lst[0] = 32'h0; lm[0] = 32'h0; lst[1] = 32'h0; lm[1] = 32'h0;
`ifdef G_AETCAM_SHADOW_EN
        rd_addr_a = 6'd0; rd_addr_b = 6'd50;
`endif
        repeat (2) @(negedge clk);
        chk("reset_wen", wen, 64'h0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_vv", vv, 64'h0);
        chk("reset_ready_low", 64'(rdy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(rdy), 64'd1);
        chk("reset_st", 64'(w_st), 64'h0);
        chk("reset_m", 64'(w_m), 64'h0);

        do_cmd(1'b0, 2'd0, 6'd5, 32'hA5A5_00FF, 32'h0000_FF0F);
        do_cmd(1'b0, 2'd1, 6'd5, 32'hFFFF_FFFF, 32'h0);
        do_cmd(1'b0, 2'd0, 6'd0, 32'h1111_2222, 32'h0);
        do_cmd(1'b0, 2'd0, 6'd3, 32'hFFFF_FFFF, 32'hF0F0_F0F0);
        do_cmd(1'b0, 2'd0, 6'd63, 32'h8000_0001, 32'h0000_0001);
        do_cmd(1'b0, 2'd0, 6'd3, 32'h0BAD_CAFE, 32'h0);
        do_clear(-1);

        do_cmd(1'b1, 2'd0, 6'd10, 32'h0000_ABCD, 32'h0000_000F);
        do_cmd(1'b1, 2'd0, 6'd50, 32'hFFFF_FFFF, 32'h0);
        do_cmd(1'b1, 2'd3, 6'd2, 32'h1234_5678, 32'h0);
        do_cmd(1'b1, 2'd1, 6'd47, 32'h0, 32'h0);
        do_cmd(1'b0, 2'd3, 6'd1, 32'h5555_5555, 32'h0);

        do_cmd(1'b0, 2'd0, 6'd40, 32'h7777_0000, 32'h0);
        do_clear(10);
        rst_n = 1'b1;
        do_cmd(1'b0, 2'd0, 6'd9, 32'hCAFE_F00D, 32'h00FF_0000);

`ifdef G_AETCAM_SHADOW_EN
        do_cmd(1'b0, 2'd0, 6'd7, 32'h0000_1234, 32'h0000_00F0);
        @(negedge clk);
        rd_addr_a = 6'd7;
        @(negedge clk);
        chk("rd_st", 64'(rd_st_a), 64'h1204);
        chk("rd_m", 64'(rd_m_a), 64'h00F0);
        chk("rd_valid", 64'(rd_valid_a), 64'd1);
        chk("rd_oob_st", 64'(rd_st_b), 64'h0);
        chk("rd_oob_valid", 64'(rd_valid_b), 64'd0);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
